// File: rtl/regsel_decoder_multi_if.sv
// Select/decode bus between the writeback stage and the register-file write-enable decoder.
// The master drives selects and control; the slave returns the registered decode results.
interface regsel_decoder_multi_if #(
    parameter int SEL_W     = 4,
    parameter int NUM_PORTS = 2,
    parameter int CNT_W     = 8
);
    logic                              stall;
    logic                              cnt_clr;
    logic [NUM_PORTS-1:0]              en;
    logic [NUM_PORTS*SEL_W-1:0]        sel;
    logic [NUM_PORTS*(2**SEL_W)-1:0]   dec_out;
    logic [2**SEL_W-1:0]               any_out;
    logic                              conflict;
    logic [CNT_W-1:0]                  conflict_cnt;

    modport master (
        output stall, cnt_clr, en, sel,
        input  dec_out, any_out, conflict, conflict_cnt
    );

    modport slave (
        input  stall, cnt_clr, en, sel,
        output dec_out, any_out, conflict, conflict_cnt
    );
endinterface

// File: rtl/regsel_decoder_multi.sv
// Registered multi-port register-select decoder with lowest-index collision resolution,
// optional R0 masking and a saturating collision counter.
module regsel_decoder_multi #(
    parameter int SEL_W     = 4,
    parameter int NUM_PORTS = 2,
    parameter int ZERO_MASK = 1,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    regsel_decoder_multi_if.slave bus
);
    localparam int LINES = 2**SEL_W;

    logic [SEL_W-1:0]           sel_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0]       hit;
    logic [NUM_PORTS-1:0]       win;
    logic [NUM_PORTS*LINES-1:0] dec_next, dec_reg;
    logic [LINES-1:0]           any_next, any_reg;
    logic                       conflict_next, conflict_reg;
    logic [CNT_W-1:0]           cnt_next, cnt_reg;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic blocked;

            assign sel_arr[gi] = bus.sel[gi*SEL_W +: SEL_W];
            // A masked R0 select is not a hit, so it can neither win nor lose a collision.
            assign hit[gi] = bus.en[gi] && !((ZERO_MASK != 0) && (sel_arr[gi] == '0));

            always_comb begin
                blocked = 1'b0;
                for (int q = 0; q < gi; q++) begin
                    if (hit[q] && (sel_arr[q] == sel_arr[gi])) begin
                        blocked = 1'b1;
                    end
                end
            end

            assign win[gi] = hit[gi] && !blocked;
            assign dec_next[gi*LINES +: LINES] =
                win[gi] ? ({{(LINES-1){1'b0}}, 1'b1} << sel_arr[gi]) : '0;
        end
    endgenerate

    always_comb begin
        any_next = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            any_next = any_next | dec_next[p*LINES +: LINES];
        end
    end

    assign conflict_next = |(hit & ~win);

    // Clear beats a same-cycle conflict; the count saturates instead of wrapping.
    always_comb begin
        cnt_next = cnt_reg;
        if (bus.cnt_clr) begin
            cnt_next = '0;
        end else if (conflict_next && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_reg      <= '0;
            any_reg      <= '0;
            conflict_reg <= 1'b0;
            cnt_reg      <= '0;
        end else if (!bus.stall) begin
            dec_reg      <= dec_next;
            any_reg      <= any_next;
            conflict_reg <= conflict_next;
            cnt_reg      <= cnt_next;
        end
    end

    assign bus.dec_out      = dec_reg;
    assign bus.any_out      = any_reg;
    assign bus.conflict     = conflict_reg;
    assign bus.conflict_cnt = cnt_reg;
endmodule

// File: tb/tb_regsel_decoder_multi.sv
// Runs three decoder configurations side by side against a list-based reference model,
// with literal expectations on the directed steps and a long randomized phase.
module tb_regsel_decoder_multi;
    logic clk = 1'b0;
    logic rst;
    logic stall;
    logic cnt_clr;
    logic chk_on = 1'b0;
    int   nchk = 0;
    int   nerr = 0;
    int   txn  = 0;

    always #5 clk = ~clk;

    // A: defaults. B: no R0 mask, 2-bit counter. C: 4 ports, 5-bit selects.
    regsel_decoder_multi_if #(.SEL_W(4), .NUM_PORTS(2), .CNT_W(8)) ifa ();
    regsel_decoder_multi_if #(.SEL_W(4), .NUM_PORTS(2), .CNT_W(2)) ifb ();
    regsel_decoder_multi_if #(.SEL_W(5), .NUM_PORTS(4), .CNT_W(8)) ifc ();

    assign ifa.stall = stall;  assign ifa.cnt_clr = cnt_clr;
    assign ifb.stall = stall;  assign ifb.cnt_clr = cnt_clr;
    assign ifc.stall = stall;  assign ifc.cnt_clr = cnt_clr;

    regsel_decoder_multi #(.SEL_W(4), .NUM_PORTS(2), .ZERO_MASK(1), .CNT_W(8))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    regsel_decoder_multi #(.SEL_W(4), .NUM_PORTS(2), .ZERO_MASK(0), .CNT_W(2))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    regsel_decoder_multi #(.SEL_W(5), .NUM_PORTS(4), .ZERO_MASK(1), .CNT_W(8))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct {
        logic [127:0] dec;
        logic [31:0]  any;
        bit           conf;
        int           cnt;
    } mstate_t;

    mstate_t m [3];

    // Walk the ports in order; a hit whose register was already claimed is a loser.
    function automatic mstate_t model_next(input int np, input int sw, input int zm, input int cw,
                                           input logic [3:0] en, input logic [19:0] sel,
                                           input bit clr, input int cnt);
        mstate_t r;
        int      s [4];
        bit      hit [4];
        bit      claimed [32];
        r.dec = '0;
        r.any = '0;
        r.conf = 1'b0;
        for (int i = 0; i < 32; i++) claimed[i] = 1'b0;
        for (int p = 0; p < np; p++) begin
            s[p]   = int'((sel >> (p*sw)) & ((20'd1 << sw) - 20'd1));
            hit[p] = en[p] && !(zm != 0 && s[p] == 0);
            if (hit[p]) begin
                if (claimed[s[p]]) begin
                    r.conf = 1'b1;
                end else begin
                    claimed[s[p]] = 1'b1;
                    r.dec[p*(1 << sw) + s[p]] = 1'b1;
                    r.any[s[p]] = 1'b1;
                end
            end
        end
        if (clr)                                  r.cnt = 0;
        else if (r.conf && cnt < (1 << cw) - 1)   r.cnt = cnt + 1;
        else                                      r.cnt = cnt;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) m[k] <= '{dec: '0, any: '0, conf: 1'b0, cnt: 0};
        end else if (!stall) begin
            m[0] <= model_next(2, 4, 1, 8, 4'(ifa.en), 20'(ifa.sel), cnt_clr, m[0].cnt);
            m[1] <= model_next(2, 4, 0, 2, 4'(ifb.en), 20'(ifb.sel), cnt_clr, m[1].cnt);
            m[2] <= model_next(4, 5, 1, 8, 4'(ifc.en), 20'(ifc.sel), cnt_clr, m[2].cnt);
        end
    end

    task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at txn %0d: got %h expected %h", nm, txn, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("a_dec",  128'(ifa.dec_out),      m[0].dec);
            cmp("a_any",  128'(ifa.any_out),      128'(m[0].any));
            cmp("a_conf", 128'(ifa.conflict),     128'(m[0].conf));
            cmp("a_cnt",  128'(ifa.conflict_cnt), 128'(m[0].cnt));
            cmp("b_dec",  128'(ifb.dec_out),      m[1].dec);
            cmp("b_any",  128'(ifb.any_out),      128'(m[1].any));
            cmp("b_conf", 128'(ifb.conflict),     128'(m[1].conf));
            cmp("b_cnt",  128'(ifb.conflict_cnt), 128'(m[1].cnt));
            cmp("c_dec",  128'(ifc.dec_out),      m[2].dec);
            cmp("c_any",  128'(ifc.any_out),      128'(m[2].any));
            cmp("c_conf", 128'(ifc.conflict),     128'(m[2].conf));
            cmp("c_cnt",  128'(ifc.conflict_cnt), 128'(m[2].cnt));
            for (int p = 0; p < 4; p++) begin
                cmp("c_onehot", 128'($countones(ifc.dec_out[p*32 +: 32]) > 1), 128'(0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        txn++;
        $display("txn %0d rst=%0b stall=%0b clr=%0b | A dec=%h cnt=%0d | B dec=%h conf=%0b cnt=%0d | C any=%h cnt=%0d",
                 txn, rst, stall, cnt_clr, ifa.dec_out, ifa.conflict_cnt,
                 ifb.dec_out, ifb.conflict, ifb.conflict_cnt, ifc.any_out, ifc.conflict_cnt);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; cnt_clr = 1'b0;
        ifa.en = 2'b11; ifa.sel = {4'd5, 4'd3};
        ifb.en = 2'b11; ifb.sel = {4'd5, 4'd3};
        ifc.en = '0;    ifc.sel = '0;
        step();
        chk_on = 1'b1;
        step();
        cmp("lit_rst_dec", 128'(ifa.dec_out), 128'(0));
        cmp("lit_rst_any", 128'(ifa.any_out), 128'(0));
        cmp("lit_rst_cnt", 128'(ifa.conflict_cnt), 128'(0));

        rst = 1'b0;
        step();
        cmp("lit_t1_dec",  128'(ifa.dec_out),  128'(32'h0020_0008));
        cmp("lit_t1_any",  128'(ifa.any_out),  128'(16'h0028));
        cmp("lit_t1_conf", 128'(ifa.conflict), 128'(0));

        ifa.sel = {4'd7, 4'd7}; ifb.sel = {4'd7, 4'd7};
        step();
        cmp("lit_t2_dec",  128'(ifa.dec_out),      128'(32'h0000_0080));
        cmp("lit_t2_conf", 128'(ifa.conflict),     128'(1));
        cmp("lit_t2_cnt",  128'(ifa.conflict_cnt), 128'(1));

        ifa.sel = '0; ifb.sel = '0;
        step();
        cmp("lit_t3_dec",   128'(ifa.dec_out),      128'(0));
        cmp("lit_t3_conf",  128'(ifa.conflict),     128'(0));
        cmp("lit_t3_cnt",   128'(ifa.conflict_cnt), 128'(1));
        cmp("lit_t3b_dec",  128'(ifb.dec_out),      128'(32'h0000_0001));
        cmp("lit_t3b_conf", 128'(ifb.conflict),     128'(1));

        stall = 1'b1; cnt_clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifa.en = 2'($urandom); ifa.sel = 8'($urandom);
            ifb.en = 2'($urandom); ifb.sel = 8'($urandom);
            step();
            cmp("lit_t4_dec",  128'(ifa.dec_out),      128'(0));
            cmp("lit_t4_cnt",  128'(ifa.conflict_cnt), 128'(1));
            cmp("lit_t4b_dec", 128'(ifb.dec_out),      128'(32'h0000_0001));
            cmp("lit_t4b_cnt", 128'(ifb.conflict_cnt), 128'(2));
        end
        stall = 1'b0; cnt_clr = 1'b0;
        ifa.en = 2'b11; ifa.sel = {4'd2, 4'd9};
        ifb.en = 2'b00;
        step();
        cmp("lit_t4_rel_dec", 128'(ifa.dec_out),      128'(32'h0004_0200));
        cmp("lit_t4_rel_cnt", 128'(ifa.conflict_cnt), 128'(1));

        cnt_clr = 1'b1; ifa.en = 2'b00;
        step();
        cnt_clr = 1'b0;
        ifb.en = 2'b11; ifb.sel = {4'd3, 4'd3};
        for (int i = 0; i < 5; i++) begin
            step();
            cmp("lit_t5_sat", 128'(ifb.conflict_cnt), 128'((i < 3) ? i + 1 : 3));
        end
        cnt_clr = 1'b1;
        step();
        cmp("lit_t5_clr_cnt",  128'(ifb.conflict_cnt), 128'(0));
        cmp("lit_t5_clr_conf", 128'(ifb.conflict),     128'(1));

        for (int i = 0; i < 10000; i++) begin
            rst     = ($urandom_range(0, 499) == 0);
            stall   = ($urandom_range(0, 7) == 0);
            cnt_clr = ($urandom_range(0, 15) == 0);
            ifa.en = 2'($urandom); ifa.sel = 8'($urandom);
            ifb.en = 2'($urandom); ifb.sel = 8'($urandom);
            ifc.en = 4'($urandom);
            // Narrow the select range half the time so collisions are frequent.
            if ($urandom_range(0, 1) == 0) ifc.sel = 20'($urandom);
            else for (int p = 0; p < 4; p++) ifc.sel[p*5 +: 5] = 5'($urandom_range(0, 3));
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
